audio_compressor: RTL and testbench



---
 rtl/compressor_pkg.sv | 12 +
 rtl/compressor_channel.sv | 78 +++++++
 rtl/audio_compressor.sv | 43 ++++
 tb/tb_audio_compressor.sv | 129 ++++++++++++
 4 files changed

// File: rtl/compressor_pkg.sv
// Shared types and default tuning values for the stereo hard-knee compressor.
package compressor_pkg;

    localparam int WIDTH_DEFAULT        = 16;
    localparam int THRESH_DEFAULT       = 16384;
    localparam int RATIO_SHIFT_DEFAULT  = 2;
    localparam int MAKEUP_SHIFT_DEFAULT = 1;

    typedef logic signed [WIDTH_DEFAULT-1:0] sample_t;
    typedef logic        [WIDTH_DEFAULT:0]   mag_t;

endpackage

// File: rtl/compressor_channel.sv
// One channel of the compressor: a two-stage pipeline (magnitude/knee, then gain/re-sign).
// Makeup gain is enabled by defining COMPRESSOR_MAKEUP_EN.
module compressor_channel
    import compressor_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEFAULT,
    parameter int THRESH       = THRESH_DEFAULT,
    parameter int RATIO_SHIFT  = RATIO_SHIFT_DEFAULT,
    parameter int MAKEUP_SHIFT = MAKEUP_SHIFT_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] sample_in,
    output logic signed [WIDTH-1:0] sample_out
);

    // Gain path is wide enough to hold a full-scale magnitude after makeup.
    localparam int EXT_W = WIDTH + 1 + MAKEUP_SHIFT;

    localparam logic [WIDTH:0]          KNEE    = (WIDTH+1)'(THRESH);
    localparam logic [EXT_W-1:0]        POS_MAG = EXT_W'((64'd1 << (WIDTH-1)) - 64'd1);
    localparam logic [EXT_W-1:0]        NEG_MAG = EXT_W'(64'd1 << (WIDTH-1));
    localparam logic signed [WIDTH-1:0] S_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0]          extended;
    logic [WIDTH:0]          magnitude;
    logic                    sign_q;
    logic [WIDTH:0]          mag_q;
    logic                    above_q;
    logic [WIDTH:0]          excess;
    logic [WIDTH:0]          cmag;
    logic [EXT_W-1:0]        gained;
    logic signed [WIDTH-1:0] result;

    // One extra bit lets the most negative sample produce its exact magnitude.
    always_comb begin
        extended  = {sample_in[WIDTH-1], sample_in};
        magnitude = sample_in[WIDTH-1] ? -extended : extended;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sign_q  <= 1'b0;
            mag_q   <= '0;
            above_q <= 1'b0;
        end else begin
            sign_q  <= sample_in[WIDTH-1];
            mag_q   <= magnitude;
            above_q <= (magnitude > KNEE);
        end
    end

    always_comb begin
        excess = mag_q - KNEE;
        cmag   = above_q ? (KNEE + (excess >> RATIO_SHIFT)) : mag_q;
`ifdef COMPRESSOR_MAKEUP_EN
        gained = EXT_W'(cmag) << MAKEUP_SHIFT;
`else
        gained = EXT_W'(cmag);
`endif
        // Negative side can reach one step further than the positive side.
        if (sign_q) begin
            result = (gained > NEG_MAG) ? S_MIN : -gained[WIDTH-1:0];
        end else begin
            result = (gained > POS_MAG) ? S_MAX : gained[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sample_out <= '0;
        end else begin
            sample_out <= result;
        end
    end

endmodule

// File: rtl/audio_compressor.sv
// Stereo hard-knee compressor: two identical, independent channel pipelines.
// Makeup gain is enabled by defining COMPRESSOR_MAKEUP_EN.
module audio_compressor
    import compressor_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEFAULT,
    parameter int THRESH       = THRESH_DEFAULT,
    parameter int RATIO_SHIFT  = RATIO_SHIFT_DEFAULT,
    parameter int MAKEUP_SHIFT = MAKEUP_SHIFT_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] inleft,
    input  logic signed [WIDTH-1:0] inright,
    output logic signed [WIDTH-1:0] outleft,
    output logic signed [WIDTH-1:0] outright
);

    compressor_channel #(
        .WIDTH        (WIDTH),
        .THRESH       (THRESH),
        .RATIO_SHIFT  (RATIO_SHIFT),
        .MAKEUP_SHIFT (MAKEUP_SHIFT)
    ) left_channel (
        .clock      (clock),
        .reset      (reset),
        .sample_in  (inleft),
        .sample_out (outleft)
    );

    compressor_channel #(
        .WIDTH        (WIDTH),
        .THRESH       (THRESH),
        .RATIO_SHIFT  (RATIO_SHIFT),
        .MAKEUP_SHIFT (MAKEUP_SHIFT)
    ) right_channel (
        .clock      (clock),
        .reset      (reset),
        .sample_in  (inright),
        .sample_out (outright)
    );

endmodule

// File: tb/tb_audio_compressor.sv
// Scoreboard bench for audio_compressor: expected samples are queued on drive and
// popped two edges later, when the DUT output for that input is due.
module tb_audio_compressor;
    import compressor_pkg::*;

    typedef struct {
        int left;
        int right;
    } expect_t;

    logic    clock;
    logic    reset;
    sample_t inleft;
    sample_t inright;
    sample_t outleft;
    sample_t outright;

    expect_t scoreboard[$];
    int      numVectors;
    int      numMiscompares;

    audio_compressor dut (
        .clock    (clock),
        .reset    (reset),
        .inleft   (inleft),
        .inright  (inright),
        .outleft  (outleft),
        .outright (outright)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model in plain integer arithmetic.
    function automatic int compress(input int x);
        int m;
        int c;
        int v;
        m = (x < 0) ? -x : x;
        c = (m > 16384) ? 16384 + (m - 16384) / 4 : m;
`ifdef COMPRESSOR_MAKEUP_EN
        c = c * 2;
`endif
        v = (x < 0) ? -c : c;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        numVectors++;
        if (actual !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One clock: drive before the edge, then score the output just after it.
    task automatic applyStimulus(input string tag, input int l, input int r, input logic rst);
        expect_t e;
        @(negedge clock);
        inleft  = sample_t'(l);
        inright = sample_t'(r);
        reset   = rst;
        @(posedge clock);
        #1;
        if (!rst) begin
            scoreboard.delete();
            checkOutput({tag, "_rst_l"}, int'(outleft), 0);
            checkOutput({tag, "_rst_r"}, int'(outright), 0);
            e.left  = 0;
            e.right = 0;
            scoreboard.push_back(e);
        end else begin
            e.left  = compress(l);
            e.right = compress(r);
            scoreboard.push_back(e);
            if (scoreboard.size() >= 2) begin
                e = scoreboard.pop_front();
                checkOutput({tag, "_l"}, int'(outleft), e.left);
                checkOutput({tag, "_r"}, int'(outright), e.right);
            end
        end
    endtask

    initial begin
        numVectors     = 0;
        numMiscompares = 0;
        reset   = 1'b0;
        inleft  = '0;
        inright = '0;

        applyStimulus("reset0", 1234, -777, 1'b0);
        applyStimulus("reset1", -5000, 30000, 1'b0);
        applyStimulus("release", 1000, 0, 1'b1);

        applyStimulus("below", 1000, -16384, 1'b1);
        applyStimulus("above", 20000, -20000, 1'b1);
        applyStimulus("knee1", 16385, -16385, 1'b1);
        applyStimulus("extreme", 32767, -32768, 1'b1);
        applyStimulus("extreme2", -32768, 32767, 1'b1);

        applyStimulus("stream", 1000, 0, 1'b1);
        applyStimulus("stream", 20000, 1, 1'b1);
        applyStimulus("stream", -20000, -1, 1'b1);
        applyStimulus("stream", 0, 16384, 1'b1);
        applyStimulus("stream", 20000, 20000, 1'b1);
        applyStimulus("stream", 20000, -20000, 1'b1);

        applyStimulus("midreset", 20000, -20000, 1'b0);
        applyStimulus("after", 1000, 2000, 1'b1);
        applyStimulus("after", -3000, 4000, 1'b1);

        for (int i = 0; i < 40; i++) begin
            applyStimulus("random",
                          int'($urandom_range(0, 65535)) - 32768,
                          int'($urandom_range(0, 65535)) - 32768,
                          1'b1);
        end

        for (int i = 0; i < 2; i++) begin
            applyStimulus("drain", 0, 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule
